// File: rtl/speed_select_pkg.sv
// Shared constants, types and helpers for the speed_select input-conditioning stage.
// Key/switch role indices live here so the top level never hard-codes board pin positions.
package speed_pkg;

  localparam int N_SPEEDS    = 5;
  localparam int DEFAULT_IDX = 1;
  localparam int IDX_W       = 3;

  localparam int KEY_FASTER  = 0;
  localparam int KEY_SLOWER  = 1;
  localparam int KEY_DEFAULT = 3;
  localparam int SW_MODE     = 9;

  typedef logic [IDX_W-1:0] speed_idx_t;

  typedef enum logic {
    MODE_SWITCH = 1'b0,
    MODE_KEY    = 1'b1
  } mode_e;

  // Lowest set bit wins, so SW[0] has the highest priority.
  function automatic speed_idx_t lowest_set(input logic [N_SPEEDS-1:0] req);
    speed_idx_t idx;
    idx = '0;
    for (int i = N_SPEEDS - 1; i >= 0; i--) begin
      if (req[i]) idx = speed_idx_t'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/speed_select_if.sv
// Board-facing bundle: raw switches/keys in, resolved speed selection out.
interface speed_select_if;
  import speed_pkg::*;

  logic [9:0]          SW;
  logic [3:0]          KEY;
  logic [N_SPEEDS-1:0] speed_sel;
  logic [IDX_W-1:0]    speed_idx;
  logic                speed_change;

  modport master (
    output SW,
    output KEY,
    input  speed_sel,
    input  speed_idx,
    input  speed_change
  );

  modport slave (
    input  SW,
    input  KEY,
    output speed_sel,
    output speed_idx,
    output speed_change
  );

endinterface

// File: rtl/speed_select_debounce.sv
// One-bit 2-flop synchronizer followed by a stability-window debouncer.
// The stable value only flips after DB_CYCLES consecutive mismatching samples.
module debounce #(
  parameter int   DB_CYCLES = 500000,
  parameter logic RST_VAL   = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic i_din,
  output logic o_stable
);

  localparam int CNT_W = (DB_CYCLES > 2) ? $clog2(DB_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DB_CYCLES - 1);

  logic             r_sync1;
  logic             r_sync2;
  logic             r_stable;
  logic [CNT_W-1:0] r_count;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sync1 <= RST_VAL;
      r_sync2 <= RST_VAL;
    end else begin
      r_sync1 <= i_din;
      r_sync2 <= r_sync1;
    end
  end

  // Any sample that agrees with the stable value restarts the window.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_stable <= RST_VAL;
      r_count  <= '0;
    end else if (r_sync2 == r_stable) begin
      r_count  <= '0;
    end else if (r_count == CNT_LAST) begin
      r_stable <= ~r_stable;
      r_count  <= '0;
    end else begin
      r_count  <= r_count + CNT_W'(1);
    end
  end

  assign o_stable = r_stable;

endmodule

// File: rtl/speed_select.sv
// Resolves debounced switches and keys into a registered one-hot blink-speed
// selection plus a one-cycle change pulse for the downstream blinker.
module speed_select
  import speed_pkg::*;
#(
  parameter int DB_CYCLES   = 500000,
  parameter int DEFAULT_IDX = speed_pkg::DEFAULT_IDX
) (
  input  logic          CLOCK_50,
  input  logic          RESET,
  speed_select_if.slave bus
);

  // Debounced bit layout: speed switches, mode switch, then the three keys.
  localparam int N_DB       = N_SPEEDS + 4;
  localparam int DB_MODE    = N_SPEEDS;
  localparam int DB_FASTER  = N_SPEEDS + 1;
  localparam int DB_DEFAULT = N_SPEEDS + 3;

  localparam speed_idx_t MAX_IDX = speed_idx_t'(N_SPEEDS - 1);
  localparam speed_idx_t RST_IDX = speed_idx_t'(DEFAULT_IDX);

  logic [N_DB-1:0]     w_raw;
  logic [N_DB-1:0]     w_db;
  logic [2:0]          w_keyDb;
  logic [2:0]          w_press;
  logic                w_unused;
  mode_e               w_mode;
  speed_idx_t          w_nextIdx;

  logic [2:0]          r_keyPrev;
  speed_idx_t          r_speedIdx;
  logic [N_SPEEDS-1:0] r_speedSel;
  logic                r_speedChange;

  assign w_raw = {bus.KEY[KEY_DEFAULT], bus.KEY[KEY_SLOWER], bus.KEY[KEY_FASTER],
                  bus.SW[SW_MODE], bus.SW[N_SPEEDS-1:0]};

  assign w_unused = ^{bus.SW[SW_MODE-1:N_SPEEDS], bus.KEY[2]};

  for (genvar g = 0; g < N_DB; g++) begin : g_db
    debounce #(
      .DB_CYCLES (DB_CYCLES),
      .RST_VAL   ((g >= DB_FASTER) ? 1'b1 : 1'b0)
    ) u_db (
      .clk      (CLOCK_50),
      .rst      (RESET),
      .i_din    (w_raw[g]),
      .o_stable (w_db[g])
    );
  end

  assign w_keyDb = w_db[DB_DEFAULT:DB_FASTER];
  assign w_press = r_keyPrev & ~w_keyDb;
  assign w_mode  = mode_e'(w_db[DB_MODE]);

  // Keys are active-low, so a press is the debounced level falling 1->0.
  always_ff @(posedge CLOCK_50 or posedge RESET) begin
    if (RESET) begin
      r_keyPrev <= 3'b111;
    end else begin
      r_keyPrev <= w_keyDb;
    end
  end

  always_comb begin
    w_nextIdx = r_speedIdx;
    if (w_mode == MODE_SWITCH) begin
      if (|w_db[N_SPEEDS-1:0]) begin
        w_nextIdx = lowest_set(w_db[N_SPEEDS-1:0]);
      end
    end else if (w_press[2]) begin
      w_nextIdx = RST_IDX;
    end else if (w_press[0] && !w_press[1]) begin
      if (r_speedIdx != '0) begin
        w_nextIdx = r_speedIdx - speed_idx_t'(1);
      end
    end else if (w_press[1] && !w_press[0]) begin
      if (r_speedIdx != MAX_IDX) begin
        w_nextIdx = r_speedIdx + speed_idx_t'(1);
      end
    end
  end

  // Index, one-hot and change pulse all come from the same next value so they never disagree.
  always_ff @(posedge CLOCK_50 or posedge RESET) begin
    if (RESET) begin
      r_speedIdx    <= RST_IDX;
      r_speedSel    <= N_SPEEDS'(1) << RST_IDX;
      r_speedChange <= 1'b0;
    end else begin
      r_speedIdx    <= w_nextIdx;
      r_speedSel    <= N_SPEEDS'(1) << w_nextIdx;
      r_speedChange <= (w_nextIdx != r_speedIdx);
    end
  end

  assign bus.speed_idx    = r_speedIdx;
  assign bus.speed_sel    = r_speedSel;
  assign bus.speed_change = r_speedChange;

endmodule

// File: doc/speed_select.md
# speed_select

Input-conditioning stage directly upstream of the LED blinker on the DE-class board. Synchronizes and debounces the raw slide switches and push-buttons, then resolves them into a single clean one-hot blink-speed selection (0.5 s, 1 s, 2 s, 3 s, 4 s). Also emits a change pulse so the blinker can restart its period counter. Supports two sources: direct switch selection, or step up/down with the keys.

## Interface
- DB_CYCLES, 500000, debounce stability window in clock cycles (10 ms at 50 MHz); ≥2
- N_SPEEDS, 5, number of selectable speeds
- DEFAULT_IDX, 1, speed index after reset or KEY[3] press (1 = 1 s)

Ports:
- CLOCK_50  in  1  sole clock, 50 MHz
- RESET  in  1  asynchronous, active-high reset
- SW  in  10  raw switches; SW[4:0] speed request, SW[9] mode (0 = switch, 1 = key); others ignored
- KEY  in  4  raw push-buttons, active-low; KEY[0] faster, KEY[1] slower, KEY[3] default; KEY[2] ignored
- speed_sel  out  5  one-hot speed select; bit i ↔ speed index i
- speed_idx  out  3  binary speed index, 0..N_SPEEDS-1
- speed_change  out  1  one-cycle pulse when speed_idx takes a new value

## Operation
- Every used input bit passes through a 2-flop synchronizer, then a debouncer. Used bits: SW[4:0], SW[9], KEY[0], KEY[1], KEY[3].
- Debouncer: holds a stable value and a counter.
  - Counter clears whenever the synced input equals the stable value.
  - Otherwise the counter increments. When it reaches DB_CYCLES-1, the stable value flips and the counter clears.
  - Glitches shorter than DB_CYCLES never propagate.
- Key press = debounced KEY bit falling 1→0. It is a single event per press; holding the key does not auto-repeat.
- Switch mode (debounced SW[9]=0):
  - speed_idx = index of the lowest set bit of debounced SW[4:0]; SW[0] has the highest priority.
  - If all five bits are 0, speed_idx holds its value.
  - Keys are ignored.
- Key mode (debounced SW[9]=1):
  - KEY[0] press: decrement, saturating at 0.
  - KEY[1] press: increment, saturating at N_SPEEDS-1.
  - KEY[0] and KEY[1] pressed in the same cycle: no change.
  - KEY[3] press: load DEFAULT_IDX. It overrides KEY[0] and KEY[1] in the same cycle.
  - SW[4:0] are ignored.
- Mode change key→switch: if any of SW[4:0] is set, speed_idx takes the switch-derived value on the first cycle in switch mode; otherwise it holds. Mode change switch→key: speed_idx holds.
- speed_sel = 1 << speed_idx. Both outputs are registered and always mutually consistent.
- speed_change = 1 only on a cycle where the registered speed_idx differs from its previous value. Saturated steps and reloading the same value produce no pulse.

## Timing
- Reset (async assert, sync release):
  - speed_idx = DEFAULT_IDX, speed_sel = 5'b00010, speed_change = 0.
  - Synchronizers and debounced SW values = 0; synchronizers and debounced KEY values = 1 (released).
  - Debounce counters = 0.
- Reset mid-debounce discards the partial count. Reset mid-press does not generate a press event after release of RESET unless the key goes 1→0 again after debouncing.
- Latency from a clean raw input edge to a debounced change: 2 (sync) + DB_CYCLES cycles.
- speed_idx, speed_sel and speed_change update 1 cycle after the debounced edge.
- speed_change is high for exactly 1 cycle, coincident with the first cycle of the new speed_idx.
- Back-to-back presses are limited only by debounce; each qualified press is honored.

## Structure
- Package speed_pkg holds:
  - N_SPEEDS, DEFAULT_IDX, idx width (3)
  - key role indices (KEY_FASTER=0, KEY_SLOWER=1, KEY_DEFAULT=3), mode bit index (SW_MODE=9)
  - speed index typedef
- Sub-module debounce: one bit wide, parameter DB_CYCLES and RST_VAL. Contains the 2-flop synchronizer and the stable/counter logic. Instantiated 9 times.
- Top level contains the edge detection, mode/priority logic and output registers.

## Test plan
All scenarios use DB_CYCLES=4.
- Reset: assert RESET with SW=0 and KEY=4'hF → speed_idx=1, speed_sel=5'b00010, speed_change=0. No pulse after release.
- Switch mode priority: set SW[4:0]=5'b10100 and hold ≥7 cycles → speed_idx=2, sel=5'b00100, exactly one speed_change pulse. Then clear all → idx stays 2, no pulse.
- Debounce: 3-cycle SW[0] glitch → no change. Hold SW[0] for 7 cycles → idx=0 at cycle 2+4+1 after the edge.
- Key saturation: SW[9]=1, idx=1; press KEY[1] four times → idx 2,3,4,4 with pulses on the first three only. Press KEY[0] and KEY[1] together → no change.
- Default: key mode, idx=4, press KEY[3] → idx=1 with one pulse. Press KEY[3] together with KEY[0] → idx=1, no pulse.
- Mode switch: key mode idx=3, SW[1]=1 already stable, clear SW[9] → idx=1 one cycle after debounced mode change. Reset asserted mid-press → outputs return to reset values immediately.
